// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word reads to
// IROM, buffers responses and hands {pc, inst} pairs to decode. A redirect
// flushes the buffer and marks any in-flight response as stale.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   occ_t;

  localparam occ_t DepthOcc = BUF_DEPTH[CntW:0];

  // {out_q, discard_q} encoded directly in the state value
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b10,
    StDrop = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic        out_q, discard_q;
  logic [31:0] pc_q, req_pc_q;

  logic [31:0] buf_inst [BUF_DEPTH];
  logic [31:0] buf_pc   [BUF_DEPTH];
  ptr_t        wr_ptr_q, rd_ptr_q;
  cnt_t        count_q;

  logic        pop, push, accept, rsp;
  occ_t        occ;

  assign out_q     = state_q[1];
  assign discard_q = state_q[0];

  assign id_valid  = (count_q != '0);
  assign id_inst   = buf_inst[rd_ptr_q];
  assign id_pc     = buf_pc[rd_ptr_q];
  assign pop       = id_valid && id_ready;
  assign rsp       = imem_rvalid && out_q;
  assign push      = rsp && !discard_q && !redirect_valid;

  // Request only when a buffer slot remains for it after the in-flight one lands
  always_comb begin
    occ       = {1'b0, count_q} + occ_t'(out_q) - occ_t'(pop);
    imem_addr = pc_q;
    imem_req  = rst_n && !redirect_valid && (!out_q || imem_rvalid) && (occ < DepthOcc);
  end

  assign accept = imem_req && imem_gnt;

  // Outstanding/discard state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: redirect wins; a response retires the outstanding request
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (out_q && !imem_rvalid) ? StDrop : StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (accept) state_d = StWait;
        StWait,
        StDrop: if (rsp) state_d = accept ? StWait : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // PC and PC-of-outstanding-request tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      if (accept) begin
        req_pc_q <= pc_q;
      end
    end
  end

  // Instruction buffer: circular FIFO, flushed on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_inst[wr_ptr_q] <= imem_rdata;
        buf_pc[wr_ptr_q]   <= req_pc_q;
        wr_ptr_q           <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + cnt_t'(1);
      end else if (pop && !push) begin
        count_q <= count_q - cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a single-outstanding IROM model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  // IROM model controls
  int          lat;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic        pend;
  int          wait_cnt;
  logic [31:0] paddr;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // IROM: response lat cycles after the grant, data = addr ^ A5A5_0000
  always @(posedge clk) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      wait_cnt <= 0;
      paddr    <= '0;
    end else begin
      if (pend && wait_cnt == 0) pend <= 1'b0;
      else if (pend) wait_cnt <= wait_cnt - 1;
      if (imem_req && imem_gnt) begin
        pend     <= 1'b1;
        wait_cnt <= lat - 1;
        paddr    <= imem_addr;
      end
    end
  end

  assign imem_rvalid = pend && (wait_cnt == 0);
  assign imem_rdata  = ovr_en ? ovr_data : (paddr ^ 32'hA5A5_0000);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0; imem_gnt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ovr_en = 1'b0; ovr_data = '0; id_ready = rdy; lat = l;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_gnt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ovr_en = 1'b0; ovr_data = '0; id_ready = 1'b1; lat = 1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", id_valid); end
    n_cmp++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", id_inst); end
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", id_pc); end
    n_cmp++; if (imem_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL rst_addr got %h want 1c000000", imem_addr); end
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    do_reset(1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = 32'h1C00_0000 + 32'(4 * c);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== e) begin
        n_fail++; $display("FAIL fetch_addr c%0d got %b/%h want 1/%h", c, imem_req, imem_addr, e);
      end
      n_cmp++; if (id_valid !== (c >= 2)) begin
        n_fail++; $display("FAIL fetch_valid c%0d got %b want %b", c, id_valid, c >= 2);
      end
      if (c >= 2) begin
        e = 32'h1C00_0000 + 32'(4 * (c - 2));
        n_cmp++; if (id_pc !== e || id_inst !== (e ^ 32'hA5A5_0000)) begin
          n_fail++; $display("FAIL fetch_data c%0d got %h/%h want %h/%h", c, id_pc, id_inst, e, e ^ 32'hA5A5_0000);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    do_reset(1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c%0d got %b want 0", c, imem_req); end
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (dut.count_q !== 2'd2) begin n_fail++; $display("FAIL stall_count got %0d want 2", dut.count_q); end
    tick();
    id_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = 32'h1C00_0000 + 32'(4 * c);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== e) begin
        n_fail++; $display("FAIL stall_drain c%0d got %b/%h want 1/%h", c, id_valid, id_pc, e);
      end
      tick();
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(1, 1'b0);
    tick();
    lat = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h1C00_0103;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle got valid %b req %b want 1 0", id_valid, imem_req);
    end
    tick();
    redirect_valid = 1'b0; lat = 1;
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b0 || dut.discard_q !== 1'b1) begin
      n_fail++; $display("FAIL redir_drop got valid %b discard %b want 0 1", id_valid, dut.discard_q);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C00_0100) begin
      n_fail++; $display("FAIL redir_target got %b/%h want 1/1c000100", imem_req, imem_addr);
    end
    tick();
    ovr_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale got valid %b inst %h want 0", id_valid, id_inst); end
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h1C00_0100 || id_inst !== 32'hB9A5_0100) begin
      n_fail++; $display("FAIL redir_new got %b/%h/%h want 1/1c000100/b9a50100", id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(1, 1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h1C00_0200;
    @(negedge clk);
    n_cmp++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rr_cycle got rvalid %b req %b want 1 0", imem_rvalid, imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dut.out_q !== 1'b0 || dut.discard_q !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle got out %b disc %b valid %b want 0 0 0", dut.out_q, dut.discard_q, id_valid);
    end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C00_0200) begin
      n_fail++; $display("FAIL rr_target got %b/%h want 1/1c000200", imem_req, imem_addr);
    end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h1C00_0200) begin
      n_fail++; $display("FAIL rr_deliver got %b/%h want 1/1c000200", id_valid, id_pc);
    end
  endtask

  task automatic test_gnt_stall();
    do_reset(3, 1'b1);
    imem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C00_0000 || dut.pc_q !== 32'h1C00_0000) begin
        n_fail++; $display("FAIL gnt_hold c%0d got %b/%h pc %h want 1/1c000000", c, imem_req, imem_addr, dut.pc_q);
      end
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0 || dut.pc_q !== 32'h1C00_0004) begin
        n_fail++; $display("FAIL gnt_single c%0d got req %b pc %h want 0 1c000004", c, imem_req, dut.pc_q);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h1C00_0004) begin
      n_fail++; $display("FAIL gnt_next got rv %b %b/%h want 1 1/1c000004", imem_rvalid, imem_req, imem_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h1C00_0000 || id_inst !== 32'hB9A5_0000) begin
      n_fail++; $display("FAIL gnt_data got %b/%h/%h want 1/1c000000/b9a50000", id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_reset_mid_drop();
    do_reset(3, 1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h1C00_0300;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dut.out_q !== 1'b1 || dut.discard_q !== 1'b1) begin
      n_fail++; $display("FAIL mr_drop got out %b disc %b want 1 1", dut.out_q, dut.discard_q);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || dut.out_q !== 1'b0) begin
      n_fail++; $display("FAIL mr_async got req %b valid %b out %b want 0 0 0", imem_req, id_valid, dut.out_q);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; lat = 1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C00_0000) begin
      n_fail++; $display("FAIL mr_restart got %b/%h want 1/1c000000", imem_req, imem_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mr_nostale got %b/%h want 0", id_valid, id_pc); end
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h1C00_0000 || id_inst !== 32'hB9A5_0000) begin
      n_fail++; $display("FAIL mr_first got %b/%h/%h want 1/1c000000/b9a50000", id_valid, id_pc, id_inst);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_gnt_stall();
    test_reset_mid_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
